calculadora_seq: RTL

//  Registered, parametrised successor of the 8-bit combinational calculator.

---
 rtl/calculadora_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/calculadora_seq.sv
// rtl/calculadora_seq.sv - registered calculator with accumulator; CALC_MULT_EN enables the shift-add multiplier
module calculadora_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entrada_A,
    input  logic [WIDTH-1:0] entrada_B,
    input  logic [2:0]       codigo,
    input  logic             inicio,
    output logic             pronto,
    output logic [WIDTH-1:0] saida,
    output logic             valido,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_zero,
    output logic             erro
);

    logic [WIDTH-1:0] acumulador;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   dif_ab;
    logic [WIDTH:0]   sum_acc;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_ovf;
    logic             op_err;
    logic             accept;
    logic             single_go;

    assign accept  = inicio & pronto;
    assign sum_ab  = {1'b0, entrada_A} + {1'b0, entrada_B};
    assign dif_ab  = {1'b0, entrada_A} - {1'b0, entrada_B};
    assign sum_acc = {1'b0, acumulador} + {1'b0, entrada_A};

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_err   = 1'b0;
        case (codigo)
            3'b000: op_res = '0;
            3'b001: op_res = entrada_A;
            3'b010: op_res = entrada_B;
            3'b011: begin
                op_res   = sum_ab[WIDTH-1:0];
                op_carry = sum_ab[WIDTH];
                op_ovf   = (entrada_A[WIDTH-1] == entrada_B[WIDTH-1]) &&
                           (sum_ab[WIDTH-1] != entrada_A[WIDTH-1]);
            end
            3'b100: begin
                op_res   = dif_ab[WIDTH-1:0];
                op_carry = dif_ab[WIDTH];
                op_ovf   = (entrada_A[WIDTH-1] != entrada_B[WIDTH-1]) &&
                           (dif_ab[WIDTH-1] != entrada_A[WIDTH-1]);
            end
            3'b110: begin
                op_res   = sum_acc[WIDTH-1:0];
                op_carry = sum_acc[WIDTH];
                op_ovf   = (acumulador[WIDTH-1] == entrada_A[WIDTH-1]) &&
                           (sum_acc[WIDTH-1] != acumulador[WIDTH-1]);
            end
            default: op_err = 1'b1;
        endcase
    end

`ifdef CALC_MULT_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {OCIOSO, MULT} state_t;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               mul_done;

    assign single_go = accept && (codigo != 3'b101);
    assign pronto    = (state == OCIOSO);
    assign prod_next = prod + (mplier[0] ? mcand : '0);
    assign mul_done  = (state == MULT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OCIOSO;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OCIOSO: if (accept && codigo == 3'b101) state_next = MULT;
            MULT:   if (mul_done) state_next = OCIOSO;
            default: state_next = OCIOSO;
        endcase
    end

    // One partial product per MULT cycle from the operands latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && codigo == 3'b101) begin
            mcand  <= {{WIDTH{1'b0}}, entrada_A};
            mplier <= entrada_B;
            prod   <= '0;
            cnt    <= '0;
        end else if (state == MULT) begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign single_go = accept;
    assign pronto    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida      <= '0;
            valido     <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_zero  <= 1'b0;
            erro       <= 1'b0;
            acumulador <= '0;
        end else begin
            valido <= 1'b0;
            if (single_go) begin
                saida      <= op_res;
                flag_carry <= op_carry;
                flag_ovf   <= op_ovf;
                flag_zero  <= (op_res == '0);
                erro       <= op_err;
                valido     <= 1'b1;
                if (codigo == 3'b000) acumulador <= '0;
                if (codigo == 3'b110) acumulador <= sum_acc[WIDTH-1:0];
            end
`ifdef CALC_MULT_EN
            else if (mul_done) begin
                saida      <= prod_next[WIDTH-1:0];
                flag_carry <= |prod_next[2*WIDTH-1:WIDTH];
                flag_ovf   <= 1'b0;
                flag_zero  <= (prod_next[WIDTH-1:0] == '0);
                erro       <= 1'b0;
                valido     <= 1'b1;
            end
`endif
        end
    end

endmodule
